// File: rtl/sram_req_adapter.sv
// Val/rdy request/response front-end for a single-port SRAM macro (1-cycle read latency).
// Optional perf counters are built in when SRAM_REQ_ADAPTER_PERF_EN is defined.
module sram_req_adapter #(
  parameter  int p_data_nbits  = 128,
  parameter  int p_num_entries = 256,
  localparam int c_addr_nbits  = $clog2(p_num_entries),
  localparam int c_mask_nbits  = p_data_nbits / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_val,
  output logic                    req_rdy,
  input  logic                    req_type,
  input  logic [c_addr_nbits-1:0] req_addr,
  input  logic [p_data_nbits-1:0] req_data,
  input  logic [c_mask_nbits-1:0] req_wmask,
  output logic                    resp_val,
  input  logic                    resp_rdy,
  output logic                    resp_type,
  output logic [p_data_nbits-1:0] resp_data,
  output logic                    sram_csb,
  output logic                    sram_web,
  output logic                    sram_oeb,
  output logic [c_addr_nbits-1:0] sram_a,
  output logic [p_data_nbits-1:0] sram_i,
  output logic [c_mask_nbits-1:0] sram_wbm,
`ifdef SRAM_REQ_ADAPTER_PERF_EN
  output logic [31:0]             perf_reads,
  output logic [31:0]             perf_writes,
  output logic [31:0]             perf_stalls,
`endif
  input  logic [p_data_nbits-1:0] sram_o
);

  logic                         fire;
  logic                         inflight_val;
  logic                         inflight_type;
  logic [p_data_nbits-1:0]      inflight_data;
  logic [1:0]                   count;
  logic [1:0]                   buf_type;
  logic [1:0][p_data_nbits-1:0] buf_data;
  logic                         deq;
  logic                         deq_fifo;
  logic                         enq;
  logic [1:0]                   wsel;

  // Reserve a buffer slot for every in-flight request, so a captured
  // response can always be enqueued even if the consumer stalls.
  assign req_rdy = !reset && (({1'b0, count} + {2'b0, inflight_val}) < 3'd2);
  assign fire    = req_val && req_rdy;

  assign sram_csb = !fire;
  assign sram_web = !(fire && req_type);
  assign sram_oeb = !(!reset && inflight_val && !inflight_type);
  assign sram_a   = fire ? req_addr : '0;
  assign sram_i   = fire ? req_data : '0;
  assign sram_wbm = (fire && req_type) ? req_wmask : '0;

  assign inflight_data = inflight_type ? '0 : sram_o;

  // FIFO head wins over the in-flight response to keep responses in order.
  assign resp_val  = !reset && ((count != 2'd0) || inflight_val);
  assign resp_type = (count != 2'd0) ? buf_type[0] : inflight_type;
  assign resp_data = (count != 2'd0) ? buf_data[0] : inflight_data;

  assign deq      = resp_val && resp_rdy;
  assign deq_fifo = deq && (count != 2'd0);
  assign enq      = !reset && inflight_val && !((count == 2'd0) && resp_rdy);
  assign wsel     = count - {1'b0, deq_fifo};

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_val  <= 1'b0;
      inflight_type <= 1'b0;
      count         <= 2'd0;
      buf_type      <= '0;
      buf_data      <= '0;
    end else begin
      inflight_val  <= fire;
      inflight_type <= req_type;
      count         <= count + {1'b0, enq} - {1'b0, deq_fifo};
      if (deq_fifo) begin
        buf_type[0] <= buf_type[1];
        buf_data[0] <= buf_data[1];
      end
      if (enq) begin
        buf_type[wsel[0]] <= inflight_type;
        buf_data[wsel[0]] <= inflight_data;
      end
    end
  end

`ifdef SRAM_REQ_ADAPTER_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reads  <= '0;
      perf_writes <= '0;
      perf_stalls <= '0;
    end else begin
      if (fire && !req_type && (perf_reads != '1))
        perf_reads <= perf_reads + 32'd1;
      if (fire && req_type && (perf_writes != '1))
        perf_writes <= perf_writes + 32'd1;
      if (req_val && !req_rdy && (perf_stalls != '1))
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_req_adapter.sv
// Directed bench for sram_req_adapter: behavioural SRAM, expected responses queued at
// request fire, a separate monitor pops and compares on each response handshake.
module tb_sram_req_adapter;

  logic         clk;
  logic         reset;
  logic         req_val, req_rdy, req_type;
  logic [7:0]   req_addr;
  logic [127:0] req_data;
  logic [15:0]  req_wmask;
  logic         resp_val, resp_rdy, resp_type;
  logic [127:0] resp_data;
  logic         sram_csb, sram_web, sram_oeb;
  logic [7:0]   sram_a;
  logic [127:0] sram_i, sram_o;
  logic [15:0]  sram_wbm;
`ifdef SRAM_REQ_ADAPTER_PERF_EN
  logic [31:0]  perf_reads, perf_writes, perf_stalls;
`endif

  sram_req_adapter dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_type(req_type),
    .req_addr(req_addr), .req_data(req_data), .req_wmask(req_wmask),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_type(resp_type), .resp_data(resp_data),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
    .sram_a(sram_a), .sram_i(sram_i), .sram_wbm(sram_wbm),
`ifdef SRAM_REQ_ADAPTER_PERF_EN
    .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_stalls(perf_stalls),
`endif
    .sram_o(sram_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural SRAM macro: byte-masked write, registered read data.
  logic [127:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {16{i[7:0]}};
    sram_o = '0;
  end
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        for (int b = 0; b < 16; b++)
          if (sram_wbm[b]) mem[sram_a][b*8 +: 8] <= sram_i[b*8 +: 8];
      end else begin
        sram_o <= mem[sram_a];
      end
    end
  end

  function automatic logic [127:0] pat(input int a);
    logic [7:0] v;
    v = a[7:0];
    return {16{v}};
  endfunction

  typedef struct {
    logic         t;
    logic [127:0] d;
    int           c;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           n_fire = 0;
  logic         lat_chk = 1'b0;
  logic [127:0] exp_cur = '0;
  logic         hold_prev = 1'b0;
  logic         prev_type;
  logic [127:0] prev_data;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, wanted %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Fire tracker: checks the SRAM port strobes and queues the expected response.
  always @(negedge clk) begin
    if (!reset && req_val && req_rdy) begin
      chk("port_csb", {127'd0, sram_csb}, 128'd0);
      chk("port_web", {127'd0, sram_web}, {127'd0, !req_type});
      chk("port_a",   {120'd0, sram_a}, {120'd0, req_addr});
      chk("port_wbm", {112'd0, sram_wbm}, req_type ? {112'd0, req_wmask} : 128'd0);
      sb.push_back('{t: req_type, d: (req_type ? 128'd0 : exp_cur), c: cyc});
      n_fire++;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    exp_t e;
    if (resp_val && resp_rdy) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_resp: got type %0d data %h, wanted none", resp_type, resp_data);
      end else begin
        e = sb.pop_front();
        chk("resp_type", {127'd0, resp_type}, {127'd0, e.t});
        chk("resp_data", resp_data, e.d);
        if (lat_chk) chk("resp_latency", 128'(cyc - e.c), 128'd1);
      end
    end
    if (hold_prev && !reset) begin
      chk("hold_val",  {127'd0, resp_val}, 128'd1);
      chk("hold_type", {127'd0, resp_type}, {127'd0, prev_type});
      chk("hold_data", resp_data, prev_data);
    end
    hold_prev = resp_val && !resp_rdy && !reset;
    prev_type = resp_type;
    prev_data = resp_data;
  end

  task automatic issue(input logic t, input logic [7:0] a, input logic [127:0] d,
                       input logic [15:0] m, input logic [127:0] e, output int waits);
    req_val = 1'b1; req_type = t; req_addr = a; req_data = d; req_wmask = m; exp_cur = e;
    waits = 0;
    forever begin
      @(negedge clk);
      if (req_rdy || waits >= 40) break;
      waits++;
    end
    if (waits >= 40) chk("issue_timeout", 128'd1, 128'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_val = 1'b0; req_type = 1'b0; req_addr = '0; req_data = '0; req_wmask = '0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if ((sb.size() == 0 && !resp_val) || k >= 40) break;
      k++;
    end
    chk("drain_timeout", {127'd0, (k >= 40)}, 128'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, wanted finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, stalls, base;
    reset = 1'b1; resp_rdy = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req_rdy",  {127'd0, req_rdy}, 128'd0);
    chk("rst_resp_val", {127'd0, resp_val}, 128'd0);
    chk("rst_csb",      {127'd0, sram_csb}, 128'd1);
    chk("rst_web",      {127'd0, sram_web}, 128'd1);
    chk("rst_oeb",      {127'd0, sram_oeb}, 128'd1);
    chk("rst_a",        {120'd0, sram_a}, 128'd0);
    chk("rst_i",        sram_i, 128'd0);
    chk("rst_wbm",      {112'd0, sram_wbm}, 128'd0);
`ifdef SRAM_REQ_ADAPTER_PERF_EN
    chk("rst_perf_reads",  {96'd0, perf_reads}, 128'd0);
    chk("rst_perf_writes", {96'd0, perf_writes}, 128'd0);
    chk("rst_perf_stalls", {96'd0, perf_stalls}, 128'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    // Streaming reads 0..7, one per cycle, 1-cycle latency.
    lat_chk = 1'b1;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 8'(i), '0, '0, pat(i), w);
      stalls += w;
    end
    idle();
    chk("stream_no_stall", 128'(stalls), 128'd0);
    drain();

    // Write then read back.
    issue(1'b1, 8'h05, {4{32'hDEAD_BEEF}}, 16'hFFFF, '0, w);
    issue(1'b0, 8'h05, '0, '0, {4{32'hDEAD_BEEF}}, w);
    idle();
    drain();

    // Byte mask: only byte 0 cleared.
    issue(1'b1, 8'h10, {128{1'b1}}, 16'hFFFF, '0, w);
    issue(1'b1, 8'h10, '0, 16'h0001, '0, w);
    issue(1'b0, 8'h10, '0, '0, {{120{1'b1}}, 8'h00}, w);
    idle();
    drain();
    lat_chk = 1'b0;

    // Backpressure: two accepted, then stall until the consumer drains.
    resp_rdy = 1'b0;
    base = n_fire;
    fork
      begin
        for (int i = 0; i < 4; i++) issue(1'b0, 8'(8'h20 + i), '0, '0, pat(8'h20 + i), w);
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("bp_fires",   128'(n_fire - base), 128'd2);
        chk("bp_req_rdy", {127'd0, req_rdy}, 128'd0);
        @(posedge clk); #1;
        resp_rdy = 1'b1;
      end
    join
    drain();
    chk("bp_total_fires", 128'(n_fire - base), 128'd4);

    // Reset mid-flight: in-flight read discarded, write during reset suppressed.
    issue(1'b0, 8'h30, '0, '0, pat(8'h30), w);
    reset = 1'b1;
    sb.delete();
    req_val = 1'b1; req_type = 1'b1; req_addr = 8'h30; req_data = '0; req_wmask = 16'hFFFF;
    @(negedge clk);
    chk("midrst_resp_val", {127'd0, resp_val}, 128'd0);
    chk("midrst_csb",      {127'd0, sram_csb}, 128'd1);
    chk("midrst_oeb",      {127'd0, sram_oeb}, 128'd1);
    chk("midrst_req_rdy",  {127'd0, req_rdy}, 128'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_csb2", {127'd0, sram_csb}, 128'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_resp", {127'd0, resp_val}, 128'd0);
    end
    @(posedge clk); #1;
    issue(1'b0, 8'h30, '0, '0, pat(8'h30), w);
    idle();
    drain();

    // Counter segment: 3 reads, 2 writes, 4 stall cycles after a fresh reset.
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    issue(1'b1, 8'h40, '0, 16'hFFFF, '0, w);
    issue(1'b1, 8'h41, '0, 16'hFFFF, '0, w);
    issue(1'b0, 8'h50, '0, '0, pat(8'h50), w);
    idle();
    drain();
    resp_rdy = 1'b0;
    issue(1'b0, 8'h51, '0, '0, pat(8'h51), w);
    issue(1'b0, 8'h52, '0, '0, pat(8'h52), w);
    req_val = 1'b1; req_type = 1'b0; req_addr = 8'h53;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_req_rdy", {127'd0, req_rdy}, 128'd0);
      @(posedge clk); #1;
    end
    idle();
    resp_rdy = 1'b1;
    drain();
`ifdef SRAM_REQ_ADAPTER_PERF_EN
    @(negedge clk);
    chk("perf_reads",  {96'd0, perf_reads}, 128'd3);
    chk("perf_writes", {96'd0, perf_writes}, 128'd2);
    chk("perf_stalls", {96'd0, perf_stalls}, 128'd4);
`endif

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_req_adapter.md
Name: sram_req_adapter

Overview:
- Initiator-side controller for the single-port generic SRAM macro port (CSB/WEB/OEB/A/I/O/WBM, active-low strobes, 1-cycle read latency).
- Converts a val/rdy memory request stream into SRAM port cycles, and returns a val/rdy response stream.
- Sits between cache/accelerator datapaths and a 128x256 SRAM instance.
- Provides full throughput when the consumer is always ready, and buffers responses under backpressure.

Parameters:
- p_data_nbits, 128, SRAM word width in bits; must be a multiple of 8.
- p_num_entries, 256, SRAM depth in words.
- c_addr_nbits, clog2(p_num_entries), derived; word address width.
- c_mask_nbits, p_data_nbits/8, derived; byte write-mask width.

Ports:
- clk  in  1  clock; also drives the SRAM CE pin externally.
- reset  in  1  synchronous, active-high.
- req_val  in  1  request valid.
- req_rdy  out  1  request ready.
- req_type  in  1  0=read, 1=write.
- req_addr  in  c_addr_nbits  word address.
- req_data  in  p_data_nbits  write data.
- req_wmask  in  c_mask_nbits  byte write mask; 1 = byte written.
- resp_val  out  1  response valid.
- resp_rdy  in  1  response ready.
- resp_type  out  1  echoes req_type.
- resp_data  out  p_data_nbits  read data; all-zero for writes.
- sram_csb  out  1  chip select, active-low.
- sram_web  out  1  write enable, active-low.
- sram_oeb  out  1  output enable, active-low.
- sram_a  out  c_addr_nbits  SRAM address.
- sram_i  out  p_data_nbits  SRAM write data.
- sram_wbm  out  c_mask_nbits  SRAM byte write mask; 1 = write byte.
- sram_o  in  p_data_nbits  SRAM read data; valid the cycle after a read is issued.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-high.
- During reset:
  - req_rdy=0, resp_val=0.
  - sram_csb=1, sram_web=1, sram_oeb=1.
  - sram_a, sram_i and sram_wbm are all 0.
- Issue:
  - A request fires when req_val && req_rdy.
  - In the fire cycle the SRAM port is driven combinationally: sram_csb=0, sram_web=~req_type, sram_a=req_addr, sram_i=req_data.
  - sram_wbm=req_wmask for writes and all-zero for reads.
  - When no request fires: sram_csb=1 and sram_web=1, so there is no SRAM access.
- In-flight tracking:
  - The inflight_val and inflight_type registers capture the fire in that cycle.
  - sram_oeb=0 only in the cycle after a read fire; otherwise sram_oeb=1.
- Response generation:
  - Cycle N+1 after a fire, the response is {inflight_type, read ? sram_o : 0}.
  - If the response buffer is empty, the response bypasses the buffer: resp_val=1 in cycle N+1, giving 1-cycle latency.
  - If resp_rdy=0, or the buffer is non-empty, the response is enqueued at the buffer tail.
- Response buffer:
  - 2-entry FIFO with count 0..2.
  - The FIFO head has priority over the in-flight response, so ordering is strictly in-order.
  - resp_val = (count>0) || inflight_val.
- Flow control:
  - req_rdy = !reset && (count + inflight_val < 2).
  - This guarantees a captured response always has a slot; overflow is impossible.
  - Streaming with resp_rdy=1 gives 1 request per cycle.
  - With resp_rdy held 0: at most 2 requests are accepted, then req_rdy=0 until a dequeue.
- Simultaneous events:
  - Same-cycle enqueue and dequeue keeps count unchanged.
  - A new fire in the same cycle as an in-flight capture is legal.
- Read-after-write to the same address in back-to-back cycles returns the new data; the SRAM completes the write at the clock edge.
- Reset mid-operation:
  - In-flight state and buffered responses are discarded.
  - count=0 and inflight_val=0 on the following cycle.
  - An SRAM write issued in the reset cycle is suppressed (csb=1).
- req_* inputs are sampled only on fire. resp_* outputs remain stable while resp_val && !resp_rdy.

Optional Feature:
- Macro: SRAM_REQ_ADAPTER_PERF_EN.
- When defined:
  - Adds outputs perf_reads[31:0], perf_writes[31:0] and perf_stalls[31:0].
  - perf_reads and perf_writes count read and write fires.
  - perf_stalls counts cycles with req_val && !req_rdy.
  - All counters are saturating and clear to 0 on reset.
- When undefined: the ports and registers are absent, and behaviour is otherwise identical.

Test Plan:
- Write then read: write addr 0x05, data 0xDEAD_BEEF replicated, wmask 0xFFFF; then read 0x05 with resp_rdy=1 -> write resp next cycle (type=1, data=0); read resp next cycle with data=0xDEAD_BEEF replicated.
- Byte mask: write all-ones to 0x10, then write 0 with wmask 0x0001, then read 0x10 -> data = 0xFF..FF00 (byte 0 cleared only).
- Streaming: 8 back-to-back reads of addresses 0..7 with resp_rdy=1 -> req_rdy stays 1; 8 responses on consecutive cycles, in order, each with 1-cycle latency.
- Backpressure: resp_rdy=0, req_val=1 continuously with reads 0x20..0x23 -> exactly 2 fires, then req_rdy=0; set resp_rdy=1 -> responses 0x20, 0x21, 0x22, 0x23 in order with no loss or duplication.
- Reset mid-flight: fire a read, assert reset in the next cycle -> resp_val=0 and sram_csb=1 during reset; no stale response appears after reset deasserts.
- PERF_EN: 3 reads, 2 writes, 4 stall cycles -> perf_reads=3, perf_writes=2, perf_stalls=4; all counters 0 after reset.
